// File: rtl/fft_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fft_ctrl_pkg
// Shared definitions for the FFT frame controller slice:
//   - default frame size and config word width
//   - audio sample / FFT data widths
//   - frame controller state encoding
//   - sample counter width helper
// ---------------------------------------------------------------------------
package fft_ctrl_pkg;

  localparam int DEF_FFT_SIZE = 2048;
  localparam int DEF_CFG_W    = 16;
  localparam int SAMPLE_W     = 24;
  localparam int TDATA_W      = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CFG   = 2'd1,
    ST_FILL  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // Width of a counter that indexes 0 .. fft_size-1.
  function automatic int cnt_width(input int fft_size);
    return (fft_size > 1) ? $clog2(fft_size) : 1;
  endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// ---------------------------------------------------------------------------
// axis_reg_slice
// Single-entry valid/ready holding register. A beat is captured when the
// upstream side is valid and the slot is free or being emptied this cycle;
// the held beat stays unchanged until the downstream side takes it.
//
// Ports:
//   clk       system clock
//   reset     synchronous, active-low
//   up_data   beat to capture            up_valid  upstream beat present
//   up_ready  slot can take a beat       dn_data   held beat
//   dn_valid  held beat is valid         dn_ready  downstream takes beat
// ---------------------------------------------------------------------------
module axis_reg_slice #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] up_data,
  input  logic         up_valid,
  output logic         up_ready,
  output logic [W-1:0] dn_data,
  output logic         dn_valid,
  input  logic         dn_ready
);

  assign up_ready = !dn_valid || dn_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      dn_valid <= 1'b0;
      // NOTE: the data register is reset as well because the downstream
      // interface is required to show all-zero data after reset, not just
      // an invalid beat.
      dn_data  <= '0;
    end else if (up_valid && up_ready) begin
      dn_valid <= 1'b1;
      dn_data  <= up_data;
    end else if (dn_ready) begin
      dn_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fft_frame_ctrl.sv
// ---------------------------------------------------------------------------
// fft_frame_ctrl
// Frames a stream of 24-bit audio samples into FFT_SIZE-sample frames for an
// AXI-stream FFT core. Before a frame it sends the latched config word when
// one is pending, streams the frame with tlast on the final sample, then
// waits for both the final input beat and the FFT's output-last handshake
// before counting the frame and starting the next one.
//
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   enable                run frames (an open frame always completes)
//   cfg_word, cfg_update  new FFT config word and its latch pulse
//   in_data/valid/ready   signed audio sample input
//   s_tdata/tvalid/tlast/tready  FFT data channel, tdata = {imag, real}
//   cfg_tdata/tvalid/tready      FFT config channel
//   fft_out_last          FFT output last-beat handshake
//   evt_tlast_unexpected, evt_tlast_missing, err_clr  FFT error events
//   busy                  controller not idle
//   frame_count           completed frames (wraps)
//   drop_count            samples offered while not ready (saturates)
//   err_sticky            an FFT tlast error has been seen
// ---------------------------------------------------------------------------
module fft_frame_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int FFT_SIZE = DEF_FFT_SIZE,
  parameter int CFG_W    = DEF_CFG_W
) (
  input  logic                clk,
  input  logic                reset,

  input  logic                enable,
  input  logic [CFG_W-1:0]    cfg_word,
  input  logic                cfg_update,

  input  logic [SAMPLE_W-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,

  output logic [TDATA_W-1:0]  s_tdata,
  output logic                s_tvalid,
  output logic                s_tlast,
  input  logic                s_tready,

  output logic [CFG_W-1:0]    cfg_tdata,
  output logic                cfg_tvalid,
  input  logic                cfg_tready,

  input  logic                fft_out_last,
  input  logic                evt_tlast_unexpected,
  input  logic                evt_tlast_missing,
  input  logic                err_clr,

  output logic                busy,
  output logic [15:0]         frame_count,
  output logic [15:0]         drop_count,
  output logic                err_sticky
);

  localparam int              CNT_W    = cnt_width(FFT_SIZE);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FFT_SIZE - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CFG_W-1:0] cfg_reg;
  logic             cfg_pending;
  logic [CNT_W-1:0] sample_cnt;
  logic             beat_done;     // final data beat already taken in DRAIN
  logic             fft_done;      // FFT output-last already seen in DRAIN

  logic             slice_ready;
  logic             slice_valid;
  logic             accept;
  logic             last_sample;
  logic             cfg_fire;
  logic             last_fire;
  logic             frame_done;
  logic [TDATA_W:0] slice_in;
  logic [TDATA_W:0] slice_out;

  // The low byte of each sample is discarded when it is narrowed to the
  // 16-bit real part; fold it into a named sink so the intent is explicit.
  logic             unused_low_bits;
  assign unused_low_bits = ^in_data[7:0];

  // -------------------------------------------------------------------------
  // Handshakes
  // -------------------------------------------------------------------------
  assign in_ready    = (state == ST_FILL) && slice_ready;
  assign slice_valid = (state == ST_FILL) && in_valid;
  assign accept      = slice_valid && slice_ready;
  assign last_sample = (sample_cnt == LAST_IDX);

  assign cfg_tvalid  = (state == ST_CFG);
  assign cfg_tdata   = cfg_reg;
  assign cfg_fire    = cfg_tvalid && cfg_tready;

  // The final beat of a frame can only be on the output in DRAIN, since the
  // last sample's acceptance is what moves the FSM there.
  assign last_fire   = s_tvalid && s_tready && s_tlast;

  // Both completion events may arrive in either order or in the same cycle.
  assign frame_done  = (state == ST_DRAIN)
                    && (beat_done || last_fire)
                    && (fft_done  || fft_out_last);

  assign busy        = (state != ST_IDLE);

  // -------------------------------------------------------------------------
  // Output holding register: {tlast, imag = 0, real = in_data[23:8]}
  // -------------------------------------------------------------------------
  assign slice_in = {last_sample, 16'h0000, in_data[23:8]};

  axis_reg_slice #(
    .W (TDATA_W + 1)
  ) u_out_slice (
    .clk      (clk),
    .reset    (reset),
    .up_data  (slice_in),
    .up_valid (slice_valid),
    .up_ready (slice_ready),
    .dn_data  (slice_out),
    .dn_valid (s_tvalid),
    .dn_ready (s_tready)
  );

  assign s_tlast = slice_out[TDATA_W];
  assign s_tdata = slice_out[TDATA_W-1:0];

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assignment first so every path drives state_nxt and no
    // latch is inferred for the branches that simply hold.
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (enable) state_nxt = ST_CFG;
      end
      ST_CFG: begin
        if (cfg_fire) state_nxt = ST_FILL;
      end
      ST_FILL: begin
        if (accept && last_sample) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (frame_done) begin
          if (!enable)                        state_nxt = ST_IDLE;
          else if (cfg_pending || cfg_update) state_nxt = ST_CFG;
          else                                state_nxt = ST_FILL;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State and bookkeeping registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      cfg_reg     <= '0;
      cfg_pending <= 1'b1;   // first start from IDLE always configures
      sample_cnt  <= '0;
      beat_done   <= 1'b0;
      fft_done    <= 1'b0;
      frame_count <= '0;
      drop_count  <= '0;
      err_sticky  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout so every register here
      // samples the pre-edge values and ordering inside the block is moot.
      state <= state_nxt;

      // A coincident update wins over the handshake clear: the new word has
      // not been sent yet, so it must stay pending.
      if (cfg_update) begin
        cfg_reg     <= cfg_word;
        cfg_pending <= 1'b1;
      end else if (cfg_fire) begin
        cfg_pending <= 1'b0;
      end

      if (accept) begin
        sample_cnt <= last_sample ? '0 : sample_cnt + 1'b1;
      end

      if ((state == ST_DRAIN) && !frame_done) begin
        if (last_fire)    beat_done <= 1'b1;
        if (fft_out_last) fft_done  <= 1'b1;
      end else begin
        beat_done <= 1'b0;
        fft_done  <= 1'b0;
      end

      if (frame_done) begin
        frame_count <= frame_count + 16'd1;
      end

      if (in_valid && !in_ready && (drop_count != 16'hFFFF)) begin
        drop_count <= drop_count + 16'd1;
      end

      if (evt_tlast_unexpected || evt_tlast_missing) begin
        err_sticky <= 1'b1;
      end else if (err_clr) begin
        err_sticky <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fft_frame_ctrl
// Directed bench for fft_frame_ctrl with an 8-sample frame. Inputs change
// 1 ns after the rising edge; a falling-edge monitor records every data and
// config beat that will be taken at the following rising edge.
// ---------------------------------------------------------------------------
module tb_fft_frame_ctrl;

  localparam int FFT_SIZE = 8;
  localparam int CFG_W    = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic [CFG_W-1:0] cfg_word;
  logic             cfg_update;
  logic [23:0]      in_data;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      s_tdata;
  logic             s_tvalid;
  logic             s_tlast;
  logic             s_tready;
  logic [CFG_W-1:0] cfg_tdata;
  logic             cfg_tvalid;
  logic             cfg_tready;
  logic             fft_out_last;
  logic             evt_tlast_unexpected;
  logic             evt_tlast_missing;
  logic             err_clr;
  logic             busy;
  logic [15:0]      frame_count;
  logic [15:0]      drop_count;
  logic             err_sticky;

  int checks = 0;
  int errors = 0;

  logic [32:0]      exp_beats[$];
  logic [32:0]      got_beats[$];
  logic [CFG_W-1:0] exp_cfg[$];
  logic [CFG_W-1:0] got_cfg[$];

  fft_frame_ctrl #(
    .FFT_SIZE (FFT_SIZE),
    .CFG_W    (CFG_W)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .enable               (enable),
    .cfg_word             (cfg_word),
    .cfg_update           (cfg_update),
    .in_data              (in_data),
    .in_valid             (in_valid),
    .in_ready             (in_ready),
    .s_tdata              (s_tdata),
    .s_tvalid             (s_tvalid),
    .s_tlast              (s_tlast),
    .s_tready             (s_tready),
    .cfg_tdata            (cfg_tdata),
    .cfg_tvalid           (cfg_tvalid),
    .cfg_tready           (cfg_tready),
    .fft_out_last         (fft_out_last),
    .evt_tlast_unexpected (evt_tlast_unexpected),
    .evt_tlast_missing    (evt_tlast_missing),
    .err_clr              (err_clr),
    .busy                 (busy),
    .frame_count          (frame_count),
    .drop_count           (drop_count),
    .err_sticky           (err_sticky)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset === 1'b1 && s_tvalid === 1'b1 && s_tready === 1'b1)
      got_beats.push_back({s_tlast, s_tdata});
    if (reset === 1'b1 && cfg_tvalid === 1'b1 && cfg_tready === 1'b1)
      got_cfg.push_back(cfg_tdata);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] smp(input int f, input int i);
    return 24'h123456 + 24'(f * 8 + i) * 24'h010203;
  endfunction

  function automatic logic [31:0] beat_of(input int f, input int i);
    logic [23:0] s;
    s = smp(f, i);
    return {16'h0000, s[23:8]};
  endfunction

  // Present one sample for one cycle; the caller guarantees in_ready=1.
  task automatic send(input int f, input int i);
    in_valid = 1'b1;
    in_data  = smp(f, i);
    exp_beats.push_back({(i == FFT_SIZE - 1), beat_of(f, i)});
    tick();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"},   busy,        0);
    check({tag, "_tvalid"}, s_tvalid,    0);
    check({tag, "_tlast"},  s_tlast,     0);
    check({tag, "_tdata"},  s_tdata,     0);
    check({tag, "_cvalid"}, cfg_tvalid,  0);
    check({tag, "_cdata"},  cfg_tdata,   0);
    check({tag, "_inrdy"},  in_ready,    0);
    check({tag, "_frames"}, frame_count, 0);
    check({tag, "_drops"},  drop_count,  0);
    check({tag, "_err"},    err_sticky,  0);
  endtask

  task automatic compare_beats();
    check("beat_count", got_beats.size(), exp_beats.size());
    for (int k = 0; k < exp_beats.size() && k < got_beats.size(); k++)
      check($sformatf("beat%0d", k), got_beats[k], exp_beats[k]);
    check("cfg_count", got_cfg.size(), exp_cfg.size());
    for (int k = 0; k < exp_cfg.size() && k < got_cfg.size(); k++)
      check($sformatf("cfg%0d", k), got_cfg[k], exp_cfg[k]);
    got_beats.delete();
    exp_beats.delete();
    got_cfg.delete();
    exp_cfg.delete();
  endtask

  initial begin
    reset                = 1'b0;
    enable               = 1'b0;
    cfg_word             = '0;
    cfg_update           = 1'b0;
    in_data              = '0;
    in_valid             = 1'b0;
    s_tready             = 1'b0;
    cfg_tready           = 1'b0;
    fft_out_last         = 1'b0;
    evt_tlast_unexpected = 1'b0;
    evt_tlast_missing    = 1'b0;
    err_clr              = 1'b0;
    repeat (3) tick();
    check_reset_state("rst");

    // ---- Frame 0: configure with reset word 0, then 8 straight samples ----
    reset      = 1'b1;
    enable     = 1'b1;
    s_tready   = 1'b1;
    cfg_tready = 1'b1;
    tick();
    check("f0_cfg_valid", cfg_tvalid, 1);
    check("f0_cfg_data",  cfg_tdata,  0);
    check("f0_cfg_inrdy", in_ready,   0);
    check("f0_busy",      busy,       1);
    exp_cfg.push_back(16'h0000);
    tick();
    check("f0_fill_inrdy", in_ready,   1);
    check("f0_fill_cfgv",  cfg_tvalid, 0);
    for (int i = 0; i < FFT_SIZE; i++) send(0, i);
    check("f0_last_beat",  s_tlast,  1);
    check("f0_last_data",  s_tdata,  beat_of(0, 7));
    check("f0_drain_rdy",  in_ready, 0);
    // in_valid stays high through DRAIN: every DRAIN cycle is a drop.
    tick();
    check("f0_wait_fft",   frame_count, 0);
    tick();
    fft_out_last = 1'b1;
    tick();
    fft_out_last = 1'b0;
    in_valid     = 1'b0;
    check("f0_frames",     frame_count, 1);
    check("f0_drops",      drop_count,  3);
    check("f0_next_fill",  in_ready,    1);
    check("f0_no_cfg",     cfg_tvalid,  0);

    // ---- Frame 1: config update mid-frame, 5-cycle output stall ----
    send(1, 0);
    send(1, 1);
    cfg_update = 1'b1;
    cfg_word   = 16'hA5A5;
    send(1, 2);
    cfg_update = 1'b0;
    cfg_word   = 16'h0000;
    send(1, 3);
    s_tready = 1'b0;
    in_valid = 1'b1;
    in_data  = smp(1, 4);
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("stall%0d_data", c),  s_tdata,  beat_of(1, 3));
      check($sformatf("stall%0d_valid", c), s_tvalid, 1);
      check($sformatf("stall%0d_inrdy", c), in_ready, 0);
    end
    check("f1_stall_last", s_tlast, 0);
    s_tready = 1'b1;
    for (int i = 4; i < FFT_SIZE; i++) send(1, i);
    in_valid     = 1'b0;
    fft_out_last = 1'b1;   // same cycle as the final data beat
    tick();
    fft_out_last = 1'b0;
    check("f1_frames",    frame_count, 2);
    check("f1_drops",     drop_count,  8);
    check("f1_cfg_valid", cfg_tvalid,  1);
    check("f1_cfg_data",  cfg_tdata,   16'hA5A5);
    exp_cfg.push_back(16'hA5A5);
    tick();
    check("f1_fill_inrdy", in_ready, 1);

    // ---- Frame 2: enable dropped at sample 3, fft_out_last before beat ----
    for (int i = 0; i < 3; i++) send(2, i);
    enable = 1'b0;
    for (int i = 3; i < FFT_SIZE; i++) send(2, i);
    in_valid     = 1'b0;
    s_tready     = 1'b0;
    fft_out_last = 1'b1;
    tick();
    fft_out_last = 1'b0;
    tick();
    check("f2_hold_frames", frame_count, 2);
    check("f2_hold_busy",   busy,        1);
    check("f2_hold_tlast",  s_tlast,     1);
    s_tready = 1'b1;
    tick();
    check("f2_frames", frame_count, 3);
    check("f2_busy",   busy,        0);
    check("f2_inrdy",  in_ready,    0);
    tick();
    tick();
    check("idle_hold_busy", busy, 0);
    check("idle_drops",     drop_count, 8);
    compare_beats();

    // ---- Error flag ----
    evt_tlast_missing = 1'b1;
    tick();
    evt_tlast_missing = 1'b0;
    check("err_set", err_sticky, 1);
    tick();
    check("err_hold", err_sticky, 1);
    err_clr              = 1'b1;
    evt_tlast_unexpected = 1'b1;
    tick();
    evt_tlast_unexpected = 1'b0;
    check("err_set_wins", err_sticky, 1);
    tick();
    err_clr = 1'b0;
    check("err_cleared", err_sticky, 0);

    // ---- Reset in the middle of a frame ----
    enable = 1'b1;
    tick();
    check("f3_cfg_data", cfg_tdata, 16'hA5A5);
    tick();
    for (int i = 0; i < 3; i++) send(3, i);
    reset = 1'b0;
    tick();
    check_reset_state("midrst");
    reset    = 1'b1;
    in_valid = 1'b0;
    tick();
    check("post_rst_cfgv", cfg_tvalid, 1);
    check("post_rst_cfgd", cfg_tdata,  0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
